q_action_sel: RTL and testbench

Q_ACTION_SEL -- requirements
Module: q_action_sel

---
 rtl/q_action_sel_pkg.sv | 14 +
 rtl/q_action_sel_if.sv | 26 ++
 rtl/q_cmp_update.sv | 50 +++++
 rtl/q_action_sel.sv | 110 +++++++++++
 tb/tb_q_action_sel.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/q_action_sel_pkg.sv
// Shared sizing, sentinel index and FSM encoding for the Q-value action selector.
package q_pkg;
  localparam int N_CELLS = 9;
  localparam int QW      = 8;
  localparam int IDXW    = 4;
  localparam logic [IDXW-1:0] IDX_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/q_action_sel_if.sv
// Scan request, Q-table read port and result bundle; slave is the selector, master the client.
interface q_action_sel_if #(
  parameter int N_CELLS = q_pkg::N_CELLS,
  parameter int QW      = q_pkg::QW
) ();
  logic               start;
  logic [N_CELLS-1:0] occupied;
  logic               q_rd_en;
  logic [3:0]         q_addr;
  logic [QW-1:0]      q_rdata;
  logic               busy;
  logic               done;
  logic [QW-1:0]      best_q;
  logic [3:0]         best_idx;
  logic               no_move;

  modport slave (
    input  start, occupied, q_rdata,
    output q_rd_en, q_addr, busy, done, best_q, best_idx, no_move
  );

  modport master (
    output start, occupied, q_rdata,
    input  q_rd_en, q_addr, busy, done, best_q, best_idx, no_move
  );
endinterface

// File: rtl/q_cmp_update.sv
// Masked running-max step: one Q-value per valid cycle, strict greater-than keeps the lowest index on ties.
// nxt_* is the post-compare view so the caller can capture the final cell in the same cycle.
module q_cmp_update
  import q_pkg::*;
#(
  parameter int N_CELLS = q_pkg::N_CELLS,
  parameter int QW      = q_pkg::QW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               rd_vld,
  input  logic [IDXW-1:0]    idx,
  input  logic [N_CELLS-1:0] mask,
  input  logic [QW-1:0]      rdata,
  output logic [QW-1:0]      nxt_max,
  output logic [IDXW-1:0]    nxt_idx,
  output logic               nxt_vld
);
  logic [QW-1:0]   run_max;
  logic [IDXW-1:0] run_idx;
  logic            run_vld;

  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    nxt_vld = run_vld;
    if (rd_vld && !mask[idx] && (!run_vld || (rdata > run_max))) begin
      nxt_max = rdata;
      nxt_idx = idx;
      nxt_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= '0;
      run_idx <= IDX_NONE;
      run_vld <= 1'b0;
    end else if (clr) begin
      run_max <= '0;
      run_idx <= IDX_NONE;
      run_vld <= 1'b0;
    end else begin
      run_max <= nxt_max;
      run_idx <= nxt_idx;
      run_vld <= nxt_vld;
    end
  end
endmodule

// File: rtl/q_action_sel.sv
// Scans N_CELLS Q-values once per start and reports the best free cell; start to done is 11 cycles.
// Starts arriving outside IDLE are dropped, never queued.
module q_action_sel
  import q_pkg::*;
#(
  parameter int N_CELLS = q_pkg::N_CELLS,
  parameter int QW      = q_pkg::QW
) (
  input  logic            clk,
  input  logic            rst_n,
  q_action_sel_if.slave   bus
);
  state_t             state, state_nxt;
  logic [IDXW-1:0]    addr;
  logic [N_CELLS-1:0] mask;
  logic               rd_vld_d;
  logic [IDXW-1:0]    idx_d;
  logic               accept;
  logic               last_rd;
  logic [QW-1:0]      nxt_max;
  logic [IDXW-1:0]    nxt_idx;
  logic               nxt_vld;

  assign accept  = (state == S_IDLE) && bus.start;
  assign last_rd = (state == S_READ) && (addr == IDXW'(N_CELLS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_READ;
      S_READ:  if (last_rd)   state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.q_rd_en = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      S_READ:  begin bus.q_rd_en = 1'b1; bus.busy = 1'b1; end
      S_DRAIN: bus.busy = 1'b1;
      S_DONE:  begin bus.busy = 1'b1; bus.done = 1'b1; end
      default: ;
    endcase
  end

  assign bus.q_addr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (state == S_READ) begin
      addr <= last_rd ? '0 : addr + 1'b1;
    end
  end

  // Mask is frozen at the accepted start so mid-scan edits to occupied cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask <= '0;
    else if (accept) mask <= bus.occupied;
  end

  // Read data lags the strobe by one cycle; carry the index alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_d <= 1'b0;
      idx_d    <= '0;
    end else begin
      rd_vld_d <= (state == S_READ);
      idx_d    <= addr;
    end
  end

  q_cmp_update #(
    .N_CELLS (N_CELLS),
    .QW      (QW)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .rd_vld  (rd_vld_d),
    .idx     (idx_d),
    .mask    (mask),
    .rdata   (bus.q_rdata),
    .nxt_max (nxt_max),
    .nxt_idx (nxt_idx),
    .nxt_vld (nxt_vld)
  );

  // Last cell is compared on the DRAIN->DONE edge, so capture the post-compare value there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.best_q   <= '0;
      bus.best_idx <= IDX_NONE;
      bus.no_move  <= 1'b0;
    end else if (state == S_DRAIN) begin
      bus.best_q   <= nxt_vld ? nxt_max : '0;
      bus.best_idx <= nxt_vld ? nxt_idx : IDX_NONE;
      bus.no_move  <= !nxt_vld;
    end
  end
endmodule

// File: tb/tb_q_action_sel.sv
// Directed bench for q_action_sel: cycle-level reference model plus literal result checks.
module tb_q_action_sel;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] qmem [9];

  q_action_sel_if #(.N_CELLS(9), .QW(8)) bus ();

  q_action_sel #(.N_CELLS(9), .QW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Q-table: registered read, junk when not strobed so stray compares show up.
  initial bus.q_rdata = 8'h00;
  always @(posedge clk) begin
    if (bus.q_rd_en && bus.q_addr < 4'd9) bus.q_rdata <= qmem[bus.q_addr];
    else                                  bus.q_rdata <= 8'hFF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Best free cell: largest value first, then the lowest index holding it.
  task automatic model_best(input logic [8:0] m, output logic [7:0] bq,
                            output logic [3:0] bi, output logic nm);
    int mx;
    mx = -1;
    for (int i = 0; i < 9; i++)
      if (!m[i] && int'(qmem[i]) > mx) mx = int'(qmem[i]);
    bq = 8'h00; bi = 4'hF; nm = 1'b1;
    if (mx >= 0) begin
      nm = 1'b0;
      bq = 8'(mx);
      for (int i = 8; i >= 0; i--)
        if (!m[i] && int'(qmem[i]) == mx) bi = 4'(i);
    end
  endtask

  // phase = cycles since the accepted start (0 = idle)
  int         phase = 0;
  logic [7:0] e_q   = 8'h00;
  logic [3:0] e_idx = 4'hF;
  logic       e_nm  = 1'b0;
  logic [7:0] p_q;
  logic [3:0] p_idx;
  logic       p_nm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; e_q = 8'h00; e_idx = 4'hF; e_nm = 1'b0;
    end else if (phase == 0) begin
      if (bus.start) begin
        phase = 1;
        model_best(bus.occupied, p_q, p_idx, p_nm);
      end
    end else if (phase == 11) begin
      phase = 0;
    end else begin
      phase = phase + 1;
      if (phase == 11) begin e_q = p_q; e_idx = p_idx; e_nm = p_nm; end
    end
  end

  always @(negedge clk) begin
    check("busy",     32'(bus.busy),     32'(phase != 0));
    check("q_rd_en",  32'(bus.q_rd_en),  32'(phase >= 1 && phase <= 9));
    if (phase >= 1 && phase <= 9) check("q_addr", 32'(bus.q_addr), 32'(phase - 1));
    check("done",     32'(bus.done),     32'(phase == 11));
    check("best_q",   32'(bus.best_q),   32'(e_q));
    check("best_idx", 32'(bus.best_idx), 32'(e_idx));
    check("no_move",  32'(bus.no_move),  32'(e_nm));
  end

  // Runs one scan; extra=1 adds a start pulse at T+3 and one held during DONE.
  task automatic run_scan(input logic [7:0] q [9], input logic [8:0] occ, input bit extra,
                          input logic [7:0] xq, input logic [3:0] xi, input logic xnm);
    int cnt;
    bit seen;
    qmem = q;
    bus.occupied = occ;
    bus.start = 1'b1;
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin bus.start = 1'b0; bus.occupied = ~occ; end
      if (extra && cnt == 3) bus.start = 1'b1;
      if (extra && cnt == 4) bus.start = 1'b0;
      if (bus.done) seen = 1;
    end
    check("done_seen",   32'(seen), 32'd1);
    check("latency",     32'(cnt),  32'd11);
    check("lit_best_q",  32'(bus.best_q),   32'(xq));
    check("lit_best_idx",32'(bus.best_idx), 32'(xi));
    check("lit_no_move", 32'(bus.no_move),  32'(xnm));
    if (extra) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("quiet_busy", 32'(bus.busy), 32'(extra ? 1'b0 : bus.busy));
      check("quiet_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
  endtask

  logic [7:0] qa [9] = '{8'd1, 8'd212, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [7:0] qb [9] = '{8'd1, 8'd22, 8'd3, 8'd45, 8'd5, 8'd45, 8'd7, 8'd8, 8'd9};
  logic [7:0] qc [9] = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
  logic [7:0] qd [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
  logic [7:0] qz [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.occupied = '0;
    qmem = qz;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_q_rd_en",  32'(bus.q_rd_en),  32'd0);
    check("rst_q_addr",   32'(bus.q_addr),   32'd0);
    check("rst_best_q",   32'(bus.best_q),   32'd0);
    check("rst_best_idx", 32'(bus.best_idx), 32'hF);
    check("rst_no_move",  32'(bus.no_move),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(qa, 9'h000, 1'b0, 8'd212, 4'd1, 1'b0);
    run_scan(qa, 9'h002, 1'b0, 8'd9,   4'd8, 1'b0);
    run_scan(qb, 9'h000, 1'b0, 8'd45,  4'd3, 1'b0);
    run_scan(qa, 9'h1FF, 1'b0, 8'd0,   4'hF, 1'b1 == 1'b1);
    run_scan(qc, 9'h001, 1'b0, 8'd7,   4'd1, 1'b0);
    run_scan(qd, 9'h000, 1'b0, 8'd255, 4'd8, 1'b0);
    run_scan(qz, 9'h000, 1'b0, 8'd0,   4'd0, 1'b0);
    run_scan(qb, 9'h008, 1'b1, 8'd45,  4'd5, 1'b0);

    // Abort a scan with reset at T+5.
    qmem = qb;
    bus.occupied = 9'h000;
    bus.start = 1'b1;
    cnt = 0;
    while (cnt < 5) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_q_rd_en", 32'(bus.q_rd_en), 32'd0);
    check("abort_best_idx",32'(bus.best_idx),32'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_scan(qa, 9'h000, 1'b0, 8'd212, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
